// File: rtl/ps2_pkg.sv
// ps2_pkg: PS/2 protocol constants, transmitter states and default 50 MHz timing
package ps2_pkg;
  localparam logic [7:0] TERMINATE = 8'hF0;
  localparam logic [7:0] DUMMY = 8'h00;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET = 8'hFF;
  localparam logic [7:0] RESP_ACK = 8'hFA;
  localparam int INHIBIT_DEFAULT = 5000;
  localparam int TIMEOUT_DEFAULT = 1000000;
  typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_ACK, S_WAIT_IDLE} state_t;
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction
endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake and open-drain line controls of the PS/2 transmitter
interface ps2_host_tx_if;
  logic start;
  logic [7:0] data_in;
  logic ps2_clk_in;
  logic ps2_data_in;
  logic ps2_clk_oe;
  logic ps2_data_oe;
  logic busy;
  logic done;
  logic error;
  modport master (
    output start, data_in, ps2_clk_in, ps2_data_in,
    input ps2_clk_oe, ps2_data_oe, busy, done, error
  );
  modport slave (
    input start, data_in, ps2_clk_in, ps2_data_in,
    output ps2_clk_oe, ps2_data_oe, busy, done, error
  );
endinterface

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-FF synchronizers for PS/2 clock/data plus falling-edge detect on clock
module ps2_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_s,
  output logic data_s,
  output logic fall
);
  logic [1:0] cq, dq;
  logic cprev;
  // reset to the idle-high line level so leaving reset never looks like a fall
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      cq <= 2'b11;
      dq <= 2'b11;
      cprev <= 1'b1;
    end else begin
      cq <= {cq[0], clk_in};
      dq <= {dq[0], data_in};
      cprev <= cq[1];
    end
  assign clk_s = cq[1];
  assign data_s = dq[1];
  assign fall = cprev & ~cq[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter (inhibit, request-to-send,
// device-clocked frame, ack check, watchdog) driving open-drain line enables
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = INHIBIT_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input logic clock,
  input logic reset,
  ps2_host_tx_if.slave io
);
  localparam int CW = $clog2(TIMEOUT_CYCLES > INHIBIT_CYCLES ? TIMEOUT_CYCLES : INHIBIT_CYCLES) + 1;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [10:0] sh, sh_n;
  logic [3:0] n, n_n;
  logic done_n, err_n, clk_s, data_s, fall;
  ps2_sync_edge u_sync (
    .clock(clock), .reset(reset), .clk_in(io.ps2_clk_in), .data_in(io.ps2_data_in),
    .clk_s(clk_s), .data_s(data_s), .fall(fall)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      cnt <= '0;
      sh <= '1;
      n <= '0;
      io.done <= 1'b0;
      io.error <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sh <= sh_n;
      n <= n_n;
      io.done <= done_n;
      io.error <= err_n;
    end
  // sh holds {stop, parity, data[7:0], start}; sh[0] is the bit currently on the line
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sh_n = sh;
    n_n = n;
    done_n = 1'b0;
    err_n = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        n_n = '0;
        if (io.start) begin
          sh_n = {1'b1, odd_parity(io.data_in), io.data_in, 1'b0};
          state_n = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        cnt_n = cnt == CW'(INHIBIT_CYCLES - 1) ? '0 : cnt + 1'b1;
        state_n = cnt == CW'(INHIBIT_CYCLES - 1) ? S_RTS : S_INHIBIT;
      end
      S_RTS: begin
        cnt_n = '0;
        state_n = S_SEND;
      end
      S_SEND: if (fall) begin
        sh_n = {1'b1, sh[10:1]};
        n_n = n + 1'b1;
        state_n = n == 4'd9 ? S_ACK : S_SEND;
      end
      S_ACK: if (fall) begin
        state_n = data_s ? S_IDLE : S_WAIT_IDLE;
        err_n = data_s;
      end
      S_WAIT_IDLE: if (clk_s && data_s) begin
        state_n = S_IDLE;
        done_n = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
    // watchdog shared by every device-clocked state
    if (state inside {S_SEND, S_ACK, S_WAIT_IDLE}) begin
      cnt_n = fall ? '0 : cnt + 1'b1;
      if (!fall && cnt == CW'(TIMEOUT_CYCLES - 1)) begin
        state_n = S_IDLE;
        done_n = 1'b0;
        err_n = 1'b1;
      end
    end
  end
  assign io.ps2_clk_oe = state == S_INHIBIT || state == S_RTS;
  assign io.ps2_data_oe = state == S_RTS || (state == S_SEND && !sh[0]);
  assign io.busy = state != S_IDLE;
endmodule
